// File: rtl/matrix_input_collector.sv
// matrix_input_collector
//   Collects one matrix frame from a beat stream (row count, column count, then row*col
//   elements in row-major order) and hands it to the storage stage as a single write.
//   Successive committed frames go to successive global slots, wrapping at MATRIX_NUM.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_data   upstream beat; transfers when in_valid && in_ready
//   in_ready            high in every state except COMMIT
//   abort               drop the frame in progress (GET_COL / GET_DATA only)
//   wr_en               one-cycle write pulse; target_idx/write_row/write_col/data_flat valid
//   done                frame committed (same cycle as wr_en)
//   err, err_code       frame rejected pulse; 1 = bad dimension, 2 = bad element, 3 = abort
//   busy                state is not IDLE
//
// Build option
//   MATRIX_ELEM_RANGE_CHECK_EN  reject any element beat greater than 9 (err_code 2)

module matrix_input_collector #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_SIZE   = 5,
    parameter int unsigned MATRIX_NUM = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    input  logic                       abort,
    output logic                       wr_en,
    output logic [2:0]                 target_idx,
    output logic [2:0]                 write_row,
    output logic [2:0]                 write_col,
    output logic [25*DATA_WIDTH-1:0]   data_flat,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic                       busy
);

    localparam int unsigned NumElem = 25;
    localparam logic [DATA_WIDTH-1:0] MaxDim = DATA_WIDTH'(MAX_SIZE);
    localparam logic [2:0] IdxLast = 3'(MATRIX_NUM - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGetCol,
        StGetData,
        StCommit
    } state_e;

    state_e                     state_q, state_d;
    logic [2:0]                 row_q, row_d;
    logic [4:0]                 cnt_q, cnt_d;
    logic [4:0]                 total_q, total_d;
    logic [2:0]                 idx_q, idx_d;
    logic [2:0]                 wrow_q, wrow_d;
    logic [2:0]                 wcol_q, wcol_d;
    logic [25*DATA_WIDTH-1:0]   data_q, data_d;
    logic                       err_q, err_d;
    logic [1:0]                 err_code_q, err_code_d;

    logic beat;
    logic dim_bad;
    logic elem_bad;

    assign in_ready = (state_q != StCommit);
    assign beat     = in_valid && in_ready;
    assign dim_bad  = (in_data == '0) || (in_data > MaxDim);

`ifdef MATRIX_ELEM_RANGE_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] ElemMax = DATA_WIDTH'(9);
    assign elem_bad = (in_data > ElemMax);
`else
    assign elem_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        total_d    = total_q;
        idx_d      = idx_q;
        wrow_d     = wrow_q;
        wcol_d     = wcol_q;
        data_d     = data_q;
        err_d      = 1'b0;
        err_code_d = 2'd0;

        unique case (state_q)
            StIdle: begin
                if (beat) begin
                    if (dim_bad) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                    end else begin
                        row_d   = in_data[2:0];
                        state_d = StGetCol;
                    end
                end
            end
            StGetCol: begin
                // Abort beats a coincident handshake; the beat is discarded.
                if (abort) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = StIdle;
                end else if (beat) begin
                    if (dim_bad) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                        state_d    = StIdle;
                    end else begin
                        // Output dimensions and payload change only here, so the last
                        // committed frame stays visible until a new frame starts its data.
                        wrow_d  = row_q;
                        wcol_d  = in_data[2:0];
                        total_d = {2'b00, row_q} * {2'b00, in_data[2:0]};
                        cnt_d   = 5'd0;
                        data_d  = '0;
                        state_d = StGetData;
                    end
                end
            end
            StGetData: begin
                if (abort) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = StIdle;
                end else if (beat) begin
                    if (elem_bad) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                        state_d    = StIdle;
                    end else begin
                        for (int k = 0; k < NumElem; k++) begin
                            if (cnt_q == 5'(k)) begin
                                data_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
                            end
                        end
                        if (cnt_q == total_q - 5'd1) begin
                            state_d = StCommit;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
            end
            StCommit: begin
                // Slot index advances only after the write has used it.
                idx_d   = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            row_q      <= 3'd0;
            cnt_q      <= 5'd0;
            total_q    <= 5'd0;
            idx_q      <= 3'd0;
            wrow_q     <= 3'd1;
            wcol_q     <= 3'd1;
            data_q     <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            total_q    <= total_d;
            idx_q      <= idx_d;
            wrow_q     <= wrow_d;
            wcol_q     <= wcol_d;
            data_q     <= data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // The write pulse is the COMMIT state itself, so a reset during COMMIT kills it at once.
    assign wr_en      = (state_q == StCommit);
    assign done       = (state_q == StCommit);
    assign busy       = (state_q != StIdle);
    assign target_idx = idx_q;
    assign write_row  = wrow_q;
    assign write_col  = wcol_q;
    assign data_flat  = data_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_matrix_input_collector.sv
module tb_matrix_input_collector;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         abort;
    logic         wr_en;
    logic [2:0]   target_idx;
    logic [2:0]   write_row;
    logic [2:0]   write_col;
    logic [199:0] data_flat;
    logic         done;
    logic         err;
    logic [1:0]   err_code;
    logic         busy;

    matrix_input_collector #(
        .DATA_WIDTH (8),
        .MAX_SIZE   (5),
        .MATRIX_NUM (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .abort      (abort),
        .wr_en      (wr_en),
        .target_idx (target_idx),
        .write_row  (write_row),
        .write_col  (write_col),
        .data_flat  (data_flat),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   idx;
        logic [2:0]   row;
        logic [2:0]   col;
        logic [199:0] data;
    } wr_t;

    wr_t        exp_wr_q[$];
    logic [1:0] exp_err_q[$];
    int         total = 0;
    int         bad   = 0;
    int         exp_idx = 0;
    logic [7:0] el[25];
    logic       prev_wr = 1'b0;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every write / error the DUT presents against the scoreboard.
    always @(negedge clk) begin
        if (wr_en) begin
            chk("wr_gap", 200'(prev_wr), 200'(0));
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_wr", 200'(wr_en), 200'(0));
            end else begin
                wr_t e;
                e = exp_wr_q.pop_front();
                chk("target_idx", 200'(target_idx), 200'(e.idx));
                chk("write_row", 200'(write_row), 200'(e.row));
                chk("write_col", 200'(write_col), 200'(e.col));
                chk("data_flat", data_flat, e.data);
                chk("done", 200'(done), 200'(1));
            end
        end
        if (err) begin
            chk("wr_with_err", 200'(wr_en), 200'(0));
            if (exp_err_q.size() == 0) begin
                chk("unexpected_err", 200'(err), 200'(0));
            end else begin
                logic [1:0] c;
                c = exp_err_q.pop_front();
                chk("err_code", 200'(err_code), 200'(c));
            end
        end
        prev_wr <= wr_en;
    end

    task automatic beat(input logic [7:0] v, input bit ab);
        int n = 0;
        in_valid = 1'b1;
        in_data  = v;
        abort    = ab;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", 200'(in_ready), 200'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic push_wr(input int r, input int c);
        wr_t e;
        e.idx  = 3'(exp_idx);
        e.row  = 3'(r);
        e.col  = 3'(c);
        e.data = '0;
        for (int k = 0; k < r * c; k++) e.data[k*8 +: 8] = el[k];
        exp_wr_q.push_back(e);
        exp_idx = (exp_idx + 1) % 8;
    endtask

    // Sends a full frame from el[]; wr_en must be high right after the last beat.
    task automatic send_frame(input int r, input int c, input bit expect_wr);
        if (expect_wr) push_wr(r, c);
        beat(8'(r), 1'b0);
        beat(8'(c), 1'b0);
        for (int k = 0; k < r * c; k++) beat(el[k], 1'b0);
        chk("wr_latency", 200'(wr_en), 200'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_idx = 0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_target_idx", 200'(target_idx), 200'(0));
        chk("rst_write_row", 200'(write_row), 200'(1));
        chk("rst_write_col", 200'(write_col), 200'(1));
        chk("rst_data_flat", data_flat, 200'(0));
        chk("rst_wr_en", 200'(wr_en), 200'(0));
        chk("rst_done", 200'(done), 200'(0));
        chk("rst_err", 200'(err), 200'(0));
        chk("rst_err_code", 200'(err_code), 200'(0));
        chk("rst_busy", 200'(busy), 200'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        abort    = 1'b0;
        for (int k = 0; k < 25; k++) el[k] = 8'd0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 200'(in_ready), 200'(1));

        // Bad dimensions: row 6, then row 0.
        exp_err_q.push_back(2'd1);
        beat(8'd6, 1'b0);
        exp_err_q.push_back(2'd1);
        beat(8'd0, 1'b0);
        @(posedge clk); #1;

        // 2x3 frame with elements 1..6, must land in slot 0.
        for (int k = 0; k < 6; k++) el[k] = 8'(k + 1);
        send_frame(2, 3, 1'b1);
        @(posedge clk); #1;
        chk("post_commit_idle", 200'(busy), 200'(0));

        // Nine back-to-back 1x1 frames: slots 0..7 then 0.
        do_reset();
        for (int f = 0; f < 9; f++) begin
            el[0] = 8'(f + 1);
            send_frame(1, 1, 1'b1);
        end
        @(posedge clk); #1;

        // 3x3 frame aborted on the 4th element together with its beat.
        exp_err_q.push_back(2'd3);
        beat(8'd3, 1'b0);
        beat(8'd3, 1'b0);
        beat(8'd1, 1'b0);
        beat(8'd2, 1'b0);
        beat(8'd3, 1'b0);
        beat(8'd4, 1'b1);
        chk("busy_after_abort", 200'(busy), 200'(0));

        // Abort in IDLE is ignored: the row beat is still taken.
        el[0] = 8'd7;
        push_wr(1, 1);
        beat(8'd1, 1'b1);
        beat(8'd1, 1'b0);
        beat(8'd7, 1'b0);
        chk("abort_idle_wr", 200'(wr_en), 200'(1));
        @(posedge clk); #1;

        // 2x2 frame containing 12.
        el[0] = 8'd1; el[1] = 8'd12; el[2] = 8'd3; el[3] = 8'd4;
`ifdef MATRIX_ELEM_RANGE_CHECK_EN
        exp_err_q.push_back(2'd2);
        beat(8'd2, 1'b0);
        beat(8'd2, 1'b0);
        beat(8'd1, 1'b0);
        beat(8'd12, 1'b0);
        chk("busy_after_elem_err", 200'(busy), 200'(0));
`else
        send_frame(2, 2, 1'b1);
`endif
        @(posedge clk); #1;

        // Reset asserted while in COMMIT: no write may be seen.
        el[0] = 8'd9;
        send_frame(1, 1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        exp_idx = 0;
        repeat (3) @(negedge clk);
        chk("in_ready_after_rst", 200'(in_ready), 200'(1));
        chk("idx_after_rst", 200'(target_idx), 200'(0));

        chk("wr_queue_drained", 200'(exp_wr_q.size()), 200'(0));
        chk("err_queue_drained", 200'(exp_err_q.size()), 200'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
